// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM subsystem: measurement FSM encodings,
// the common tick-rate default and the duty full-scale helper.
package pwm_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_SEEK = 2'd0;
    localparam logic [STATE_W-1:0] ST_HIGH = 2'd1;
    localparam logic [STATE_W-1:0] ST_LOW  = 2'd2;

    // clk cycles per sample tick; generator and capture share this default
    localparam int unsigned TICK_DIV = 1;

    // Full-scale duty value 2^r-1
    function automatic logic [31:0] duty_max(input int unsigned r);
        return (r >= 32) ? 32'hFFFF_FFFF : ((32'd1 << r) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_div.sv
// Unsigned restoring divider producing an R-bit quotient in R clocks.
// The upper W bits of the dividend must be smaller than the divisor.
module pwm_div
    import pwm_pkg::*;
#(
    parameter int unsigned R = 8,
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W+R-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [R-1:0]   quotient
);
    localparam int unsigned CW = $clog2(R + 1);

    logic [W-1:0]  rem_q;
    logic [R-1:0]  low_q;
    logic [R-1:0]  quo_q;
    logic [CW-1:0] iter_q;

    logic [W-1:0]  rem_in_c;
    logic [R-1:0]  low_in_c;
    logic [R-1:0]  quo_in_c;
    logic [W:0]    trial_c;
    logic [W:0]    diff_c;
    logic          fits_c;
    logic [W-1:0]  rem_nxt_c;
    logic [CW-1:0] iter_nxt_c;
    logic          step_c;

    // The first iteration runs on the start cycle straight from the inputs
    assign rem_in_c   = busy ? rem_q : dividend[W+R-1:R];
    assign low_in_c   = busy ? low_q : dividend[R-1:0];
    assign quo_in_c   = busy ? quo_q : '0;
    assign trial_c    = {rem_in_c, low_in_c[R-1]};
    assign diff_c     = trial_c - {1'b0, divisor};
    assign fits_c     = (trial_c >= {1'b0, divisor});
    assign rem_nxt_c  = fits_c ? diff_c[W-1:0] : trial_c[W-1:0];
    assign iter_nxt_c = busy ? (iter_q + CW'(1)) : CW'(1);
    assign step_c     = busy | start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            low_q  <= '0;
            quo_q  <= '0;
            iter_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (step_c) begin
                rem_q  <= rem_nxt_c;
                low_q  <= low_in_c << 1;
                quo_q  <= (quo_in_c << 1) | R'(fits_c);
                iter_q <= iter_nxt_c;
                if (iter_nxt_c == CW'(R)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM input
// in prescaler ticks, converts them to an R-bit duty word and flags a stuck line.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned R   = 8,
    parameter int unsigned W   = 16,
    parameter int unsigned DIV = TICK_DIV
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [R-1:0] duty,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         stuck
);
    localparam int unsigned  PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [R-1:0] DUTY_MAX = R'(duty_max(R));

    logic          sync_q;
    logic          s;
    logic          s_prev;
    logic [PW-1:0] pre_cnt;
    logic          tick_c;
    logic          rise_c;
    logic          fall_c;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [W-1:0]       per_cnt;
    logic [W-1:0]       per_nxt;
    logic [W-1:0]       per_inc_c;
    logic [W-1:0]       hi_cap;
    logic [W-1:0]       hi_nxt;
    logic               sat_c;
    logic               capture_c;
    logic               stuck_evt_c;

    logic [W-1:0]   cap_period;
    logic [W-1:0]   cap_high;
    logic           start_q;
    logic [W+R-1:0] dividend_c;
    logic           div_busy;
    logic           div_done;
    logic [R-1:0]   div_quo;

    // Two-flop synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_q <= pwm_in;
            s      <= sync_q;
        end
    end

    assign tick_c = (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            s_prev  <= 1'b0;
        end else begin
            pre_cnt <= tick_c ? '0 : (pre_cnt + PW'(1));
            if (tick_c) begin
                s_prev <= s;
            end
        end
    end

    assign rise_c    = tick_c & s & ~s_prev;
    assign fall_c    = tick_c & ~s & s_prev;
    assign sat_c     = (per_cnt == CNT_MAX);
    assign per_inc_c = sat_c ? per_cnt : (per_cnt + W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_SEEK;
            per_cnt <= '0;
            hi_cap  <= '0;
        end else begin
            state   <= state_nxt;
            per_cnt <= per_nxt;
            hi_cap  <= hi_nxt;
        end
    end

    // An edge on the saturating tick wins over the stuck detection
    always_comb begin
        state_nxt   = state;
        per_nxt     = per_cnt;
        hi_nxt      = hi_cap;
        capture_c   = 1'b0;
        stuck_evt_c = 1'b0;
        if (tick_c) begin
            case (state)
                ST_SEEK: begin
                    if (rise_c) begin
                        state_nxt = ST_HIGH;
                        per_nxt   = W'(1);
                    end
                end
                ST_HIGH: begin
                    if (fall_c) begin
                        hi_nxt    = per_cnt;
                        per_nxt   = per_inc_c;
                        state_nxt = ST_LOW;
                    end else if (sat_c) begin
                        state_nxt   = ST_SEEK;
                        stuck_evt_c = 1'b1;
                    end else begin
                        per_nxt = per_inc_c;
                    end
                end
                ST_LOW: begin
                    if (rise_c) begin
                        capture_c = 1'b1;
                        per_nxt   = W'(1);
                        state_nxt = ST_HIGH;
                    end else if (sat_c) begin
                        state_nxt   = ST_SEEK;
                        stuck_evt_c = 1'b1;
                    end else begin
                        per_nxt = per_inc_c;
                    end
                end
                default: begin
                    state_nxt = ST_SEEK;
                end
            endcase
        end
    end

    // Captures arriving while a division is pending or running are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_period <= '0;
            cap_high   <= '0;
            start_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (capture_c && !start_q && !div_busy) begin
                cap_period <= per_cnt;
                cap_high   <= hi_cap;
                start_q    <= 1'b1;
            end
        end
    end

    assign dividend_c = {cap_high, {R{1'b0}}};

    pwm_div #(
        .R(R),
        .W(W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (start_q),
        .dividend (dividend_c),
        .divisor  (cap_period),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (div_done) begin
                duty      <= div_quo;
                period    <= cap_period;
                high_time <= cap_high;
                valid     <= 1'b1;
                stuck     <= 1'b0;
            end else if (stuck_evt_c) begin
                duty      <= s ? DUTY_MAX : '0;
                period    <= '0;
                high_time <= '0;
                valid     <= 1'b1;
                stuck     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: one instance at DIV=1, one at DIV=4,
// both with a 12-bit counter so the stuck timeout stays short.
module tb_pwm_capture;

    logic        clk;
    logic        reset;
    logic        pwm1;
    logic        pwm4;
    logic [7:0]  duty1;
    logic [7:0]  duty4;
    logic [11:0] per1;
    logic [11:0] per4;
    logic [11:0] hi1;
    logic [11:0] hi4;
    logic        valid1;
    logic        valid4;
    logic        stuck1;
    logic        stuck4;

    int tests = 0;
    int fails = 0;
    int vcnt1 = 0;
    int vcnt4 = 0;

    pwm_capture #(.R(8), .W(12), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .pwm_in(pwm1), .duty(duty1),
        .period(per1), .high_time(hi1), .valid(valid1), .stuck(stuck1)
    );

    pwm_capture #(.R(8), .W(12), .DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .pwm_in(pwm4), .duty(duty4),
        .period(per4), .high_time(hi4), .valid(valid4), .stuck(stuck4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid1) vcnt1 <= vcnt1 + 1;
        if (valid4) vcnt4 <= vcnt4 + 1;
    end

    task automatic wave1(input int hi, input int lo);
        pwm1 = 1'b1;
        repeat (hi) @(negedge clk);
        pwm1 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic gen4(input int d);
        pwm4 = 1'b1;
        repeat (4 * d) @(negedge clk);
        pwm4 = 1'b0;
        repeat (1024 - 4 * d) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pwm1  = 1'b0;
        pwm4  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({duty1, per1, hi1, valid1, stuck1} !== 34'd0) begin
            fails++;
            $display("FAIL reset_dut1: duty=%0d per=%0d hi=%0d valid=%b stuck=%b, expected all 0", duty1, per1, hi1, valid1, stuck1);
        end
        tests++;
        if ({duty4, per4, hi4, valid4, stuck4} !== 34'd0) begin
            fails++;
            $display("FAIL reset_dut4: duty=%0d per=%0d hi=%0d valid=%b stuck=%b, expected all 0", duty4, per4, hi4, valid4, stuck4);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0;
        v0 = vcnt1;
        wave1(64, 192);
        tests++;
        if (vcnt1 !== v0) begin
            fails++;
            $display("FAIL basic_first_edge: valid pulses=%0d, expected 0", vcnt1 - v0);
        end
        pwm1 = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 11 || k == 13) begin
                tests++;
                if (valid1 !== 1'b0) begin
                    fails++;
                    $display("FAIL basic_valid_off k=%0d: valid=%b, expected 0", k, valid1);
                end
            end
            if (k == 12) begin
                tests++;
                if ({valid1, per1, hi1, duty1} !== {1'b1, 12'd256, 12'd64, 8'd64}) begin
                    fails++;
                    $display("FAIL basic_meas: valid=%b per=%0d hi=%0d duty=%0d, expected 1/256/64/64", valid1, per1, hi1, duty1);
                end
            end
        end
        pwm1 = 1'b0;
        repeat (192) @(negedge clk);
        wave1(64, 192);
        tests++;
        if (vcnt1 - v0 !== 2) begin
            fails++;
            $display("FAIL basic_count: valid pulses=%0d, expected 2", vcnt1 - v0);
        end
    endtask

    task automatic test_stuck;
        int v0;
        pwm1 = 1'b1;
        for (int k = 1; k <= 4400; k++) begin
            @(negedge clk);
            if (k == 30) begin
                v0 = vcnt1;
                tests++;
                if ({per1, hi1, duty1} !== {12'd256, 12'd64, 8'd64}) begin
                    fails++;
                    $display("FAIL stuck_pre_meas: per=%0d hi=%0d duty=%0d, expected 256/64/64", per1, hi1, duty1);
                end
            end
            if (k == 4090) begin
                tests++;
                if (stuck1 !== 1'b0) begin
                    fails++;
                    $display("FAIL stuck_early: stuck=%b, expected 0", stuck1);
                end
            end
            if (k == 4110) begin
                tests++;
                if ({stuck1, duty1, per1, hi1, 32'(vcnt1 - v0)} !== {1'b1, 8'hFF, 12'd0, 12'd0, 32'd1}) begin
                    fails++;
                    $display("FAIL stuck_high: stuck=%b duty=%0h per=%0d hi=%0d pulses=%0d, expected 1/ff/0/0/1", stuck1, duty1, per1, hi1, vcnt1 - v0);
                end
            end
        end
        tests++;
        if ({stuck1, 32'(vcnt1 - v0)} !== {1'b1, 32'd1}) begin
            fails++;
            $display("FAIL stuck_hold: stuck=%b pulses=%0d, expected 1/1", stuck1, vcnt1 - v0);
        end
        wave1(64, 192);
        wave1(64, 192);
        pwm1 = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if ({stuck1, per1, hi1, duty1} !== {1'b0, 12'd256, 12'd64, 8'd64}) begin
            fails++;
            $display("FAIL stuck_clear: stuck=%b per=%0d hi=%0d duty=%0d, expected 0/256/64/64", stuck1, per1, hi1, duty1);
        end
        repeat (34) @(negedge clk);
        pwm1 = 1'b0;
        for (int k = 1; k <= 4400; k++) begin
            @(negedge clk);
            if (k == 100) v0 = vcnt1;
        end
        tests++;
        if ({stuck1, duty1, per1, hi1, 32'(vcnt1 - v0)} !== {1'b1, 8'h00, 12'd0, 12'd0, 32'd1}) begin
            fails++;
            $display("FAIL stuck_low: stuck=%b duty=%0h per=%0d hi=%0d pulses=%0d, expected 1/0/0/0/1", stuck1, duty1, per1, hi1, vcnt1 - v0);
        end
        v0 = vcnt1;
        wave1(64, 192);
        tests++;
        if ({stuck1, 32'(vcnt1 - v0)} !== {1'b1, 32'd0}) begin
            fails++;
            $display("FAIL recover_first_edge: stuck=%b pulses=%0d, expected 1/0", stuck1, vcnt1 - v0);
        end
        pwm1 = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if ({stuck1, per1, hi1, duty1} !== {1'b0, 12'd256, 12'd64, 8'd64}) begin
            fails++;
            $display("FAIL recover_meas: stuck=%b per=%0d hi=%0d duty=%0d, expected 0/256/64/64", stuck1, per1, hi1, duty1);
        end
        pwm1 = 1'b0;
        repeat (200) @(negedge clk);
    endtask

    task automatic test_fast;
        int np;
        np = 0;
        for (int p = 0; p < 64; p++) begin
            for (int h = 0; h < 2; h++) begin
                pwm1 = (h == 0);
                repeat (3) begin
                    @(negedge clk);
                    if (p >= 4 && valid1) begin
                        np++;
                        tests++;
                        if ({per1, hi1, duty1} !== {12'd6, 12'd3, 8'd128}) begin
                            fails++;
                            $display("FAIL fast_triple: per=%0d hi=%0d duty=%0d, expected 6/3/128", per1, hi1, duty1);
                        end
                    end
                end
            end
        end
        tests++;
        if (np < 28 || np > 31) begin
            fails++;
            $display("FAIL fast_count: valid pulses=%0d, expected 28..31", np);
        end
        pwm1 = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int v0;
        pwm1 = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({duty1, per1, hi1, valid1, stuck1} !== 34'd0) begin
            fails++;
            $display("FAIL reset_in_high: duty=%0d per=%0d hi=%0d valid=%b stuck=%b, expected all 0", duty1, per1, hi1, valid1, stuck1);
        end
        @(negedge clk);
        pwm1 = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        v0 = vcnt1;
        wave1(64, 192);
        wave1(64, 192);
        tests++;
        if ({32'(vcnt1 - v0), duty1} !== {32'd1, 8'd64}) begin
            fails++;
            $display("FAIL reset_relearn: pulses=%0d duty=%0d, expected 1/64", vcnt1 - v0, duty1);
        end
        pwm1 = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({duty1, per1, hi1, valid1, stuck1} !== 34'd0) begin
            fails++;
            $display("FAIL reset_in_div: duty=%0d per=%0d hi=%0d valid=%b stuck=%b, expected all 0", duty1, per1, hi1, valid1, stuck1);
        end
        v0 = vcnt1;
        repeat (20) @(negedge clk);
        pwm1 = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        wave1(64, 192);
        tests++;
        if (vcnt1 !== v0) begin
            fails++;
            $display("FAIL reset_first_edge: pulses=%0d, expected 0", vcnt1 - v0);
        end
        pwm1 = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if ({32'(vcnt1 - v0), per1, hi1, duty1} !== {32'd1, 12'd256, 12'd64, 8'd64}) begin
            fails++;
            $display("FAIL reset_second_edge: pulses=%0d per=%0d hi=%0d duty=%0d, expected 1/256/64/64", vcnt1 - v0, per1, hi1, duty1);
        end
        pwm1 = 1'b0;
        repeat (200) @(negedge clk);
    endtask

    task automatic test_async;
        int d;
        for (int ph = 0; ph < 3; ph++) begin
            pwm1 = 1'b0;
            repeat (300) @(negedge clk);
            d = int'($urandom_range(1, 4)) + (($urandom_range(0, 1) == 1) ? 5 : 0);
            #(d);
            repeat (4) begin
                pwm1 = 1'b1;
                #640;
                pwm1 = 1'b0;
                #1920;
            end
            pwm1 = 1'b1;
            #300;
            @(negedge clk);
            tests++;
            if (per1 < 12'd255 || per1 > 12'd257 || hi1 < 12'd63 || hi1 > 12'd65 || duty1 < 8'd62 || duty1 > 8'd66) begin
                fails++;
                $display("FAIL async_phase%0d: per=%0d hi=%0d duty=%0d, expected 256/64/64 within one tick", ph, per1, hi1, duty1);
            end
        end
        pwm1 = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_generator;
        logic [7:0] dl [4];
        dl[0] = 8'h80;
        dl[1] = 8'h01;
        dl[2] = 8'h7F;
        dl[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            repeat (3) gen4(int'(dl[i]));
            tests++;
            if ({per4, hi4, duty4} !== {12'd256, 12'(dl[i]), dl[i]}) begin
                fails++;
                $display("FAIL gen_duty_%0h: per=%0d hi=%0d duty=%0h, expected 256/%0d/%0h", dl[i], per4, hi4, duty4, dl[i], dl[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stuck;
        test_fast;
        test_reset_mid;
        test_async;
        test_generator;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
